wvb_wr_ctrl_ext: RTL

- Next-generation write controller for the mDOM waveform buffer. It sits between the pretrigger buffer and the waveform buffer storage.
- Converts triggers into contiguous sample writes and produces one header per waveform.
- Adds over the previous controller: auto-rearm mode, internal periodic (constant-run) trigger, a bounded maximum waveform length, and optional retrigger extension.

---
 rtl/wvb_wr_ctrl_ext.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/wvb_wr_ctrl_ext.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
//  Module      : wvb_wr_ctrl_ext
//  Description : Waveform buffer write controller. Turns triggers (external or
//                internal constant-run) into contiguous sample writes and emits
//                one header word per waveform. Supports auto-rearm and a
//                bounded maximum waveform length.
//  Options     : WVB_RETRIG_EXTEND_EN - external retrigger during a write
//                extends the waveform (still bounded by max_len_config).
//  Revision    : 1.0 - initial release
// =============================================================================
module wvb_wr_ctrl_ext #(
    parameter int P_ADR_WIDTH        = 12,
    parameter int P_HDR_WIDTH        = 80,
    parameter int P_LTC_WIDTH        = 48,
    parameter int P_PRE_CONF_WIDTH   = 5,
    parameter int P_POST_CONF_WIDTH  = 8,
    parameter int P_MAX_LEN_WIDTH    = 12,
    parameter int P_CONST_CONF_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [P_LTC_WIDTH-1:0]        ltc,
    input  logic                          trig,
    input  logic [1:0]                    trig_src,
    input  logic                          arm,
    input  logic                          trig_mode,
    input  logic [P_PRE_CONF_WIDTH-1:0]   pre_config,
    input  logic [P_POST_CONF_WIDTH-1:0]  post_config,
    input  logic [P_MAX_LEN_WIDTH-1:0]    max_len_config,
    input  logic [P_CONST_CONF_WIDTH-1:0] cnst_config,
    input  logic                          cnst_run,
    input  logic                          overflow_in,
    output logic [P_ADR_WIDTH-1:0]        wvb_wr_addr,
    output logic                          wvb_wren,
    output logic                          eoe,
    output logic [P_HDR_WIDTH-1:0]        hdr_data,
    output logic                          hdr_wren,
    output logic                          armed,
    output logic                          overflow_out
);

    localparam int c_LW       = P_MAX_LEN_WIDTH + 1;
    localparam int c_HDR_USED = 2*P_ADR_WIDTH + P_LTC_WIDTH + 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_WRITE = 2'd2,
        S_HDR   = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [P_ADR_WIDTH-1:0]          addr_q;
    logic [P_ADR_WIDTH-1:0]          start_q;
    logic [P_ADR_WIDTH-1:0]          stop_q;
    logic [P_LTC_WIDTH-1:0]          ltc_q;
    logic [1:0]                      src_q;
    logic                            cnst_q;
    logic                            ext_q;
    logic                            trunc_q;
    logic                            ovf_q;
    logic [c_LW-1:0]                 rem_q;
    logic [c_LW-1:0]                 cnt_q;
    logic [P_MAX_LEN_WIDTH-1:0]      max_q;
    logic [P_CONST_CONF_WIDTH-1:0]   tmr_q;
`ifdef WVB_RETRIG_EXTEND_EN
    logic [P_POST_CONF_WIDTH-1:0]    post_q;
`endif

    logic                            w_cnst_fire;
    logic                            w_trig_acc;
    logic                            w_ovf_set;
    logic                            w_start;
    logic [c_LW-1:0]                 w_len;
    logic                            w_end_len;
    logic                            w_end_max;
    logic                            w_last;
    logic                            w_retrig;
    logic [c_HDR_USED-1:0]           w_hdr;

    // Timer fires on the cycle its count equals the period, then restarts.
    assign w_cnst_fire = cnst_run && (cnst_config != '0) && (tmr_q == cnst_config);
    assign w_trig_acc  = trig | w_cnst_fire;
    assign w_ovf_set   = (state_q == S_ARMED) && w_trig_acc && overflow_in;
    assign w_start     = (state_q == S_ARMED) && w_trig_acc && !overflow_in;
    assign w_len       = c_LW'(pre_config) + c_LW'(post_config) + c_LW'(1);

    assign w_end_len   = (rem_q == c_LW'(1));
    assign w_end_max   = (max_q != '0) && ((cnt_q + c_LW'(1)) == c_LW'(max_q));
    assign w_last      = w_end_len | w_end_max;

`ifdef WVB_RETRIG_EXTEND_EN
    assign w_retrig    = (state_q == S_WRITE) && trig && !w_last;
`else
    assign w_retrig    = 1'b0;
`endif

    assign w_hdr = {trunc_q, ext_q, cnst_q, src_q, ltc_q, stop_q, start_q};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        armed    = 1'b0;
        wvb_wren = 1'b0;
        eoe      = 1'b0;
        hdr_wren = 1'b0;
        hdr_data = '0;
        case (state_q)
            S_IDLE: begin
                if (arm || trig_mode) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                armed = 1'b1;
                if (w_start) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wvb_wren = 1'b1;
                eoe      = w_last;
                if (w_last) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                hdr_wren = 1'b1;
                hdr_data = P_HDR_WIDTH'(w_hdr);
                state_d  = trig_mode ? S_ARMED : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: address, length tracking, header capture, timer, sticky flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            start_q <= '0;
            stop_q  <= '0;
            ltc_q   <= '0;
            src_q   <= '0;
            cnst_q  <= 1'b0;
            ext_q   <= 1'b0;
            trunc_q <= 1'b0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
            tmr_q   <= '0;
`ifdef WVB_RETRIG_EXTEND_EN
            post_q  <= '0;
`endif
        end else begin
            if (!cnst_run || w_cnst_fire) begin
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_q + P_CONST_CONF_WIDTH'(1);
            end

            // A drop in the same cycle as an arm pulse leaves the flag set.
            if (w_ovf_set) begin
                ovf_q <= 1'b1;
            end else if (arm) begin
                ovf_q <= 1'b0;
            end

            if (w_start) begin
                start_q <= addr_q;
                ltc_q   <= ltc;
                src_q   <= trig ? trig_src : 2'b11;
                cnst_q  <= !trig;
                ext_q   <= 1'b0;
                trunc_q <= 1'b0;
                rem_q   <= w_len;
                cnt_q   <= '0;
                max_q   <= max_len_config;
`ifdef WVB_RETRIG_EXTEND_EN
                post_q  <= post_config;
`endif
            end

            if (state_q == S_WRITE) begin
                addr_q <= addr_q + P_ADR_WIDTH'(1);
                cnt_q  <= cnt_q + c_LW'(1);
                if (w_last) begin
                    stop_q  <= addr_q;
                    trunc_q <= w_end_max && !w_end_len;
                end else if (w_retrig) begin
`ifdef WVB_RETRIG_EXTEND_EN
                    rem_q <= c_LW'(post_q) + c_LW'(1);
`endif
                    ext_q <= 1'b1;
                end else begin
                    rem_q <= rem_q - c_LW'(1);
                end
            end
        end
    end

    assign wvb_wr_addr  = addr_q;
    assign overflow_out = ovf_q;

endmodule
`default_nettype wire
